// File: rtl/pic_pkg.sv
// Shared definitions for the programmable interrupt controller: register selects,
// bus direction codes, FSM state encoding and a one-hot level encoder.
`timescale 1ns/1ps
package pic_pkg;

  // Register select codes on the select bus
  localparam logic [1:0] SEL_OCR = 2'b00;
  localparam logic [1:0] SEL_IMR = 2'b01;
  localparam logic [1:0] SEL_IRR = 2'b10;
  localparam logic [1:0] SEL_ISR = 2'b11;

  // Bus direction as seen by the PIC
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Level reported when an acknowledge finds nothing unmasked pending
  localparam logic [7:0] SPURIOUS_ISR = 8'h80;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StPend   = 2'b01,
    StInserv = 2'b10,
    StVect   = 2'b11
  } pic_state_e;

  // Level of the lowest set bit; ISR holds at most one bit so this is its level
  function automatic logic [2:0] encode_level(input logic [7:0] onehot);
    logic [2:0] lvl;
    lvl = '0;
    for (int i = 7; i >= 0; i--) begin
      if (onehot[i]) lvl = 3'(i);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/pic_priority.sv
// Fixed-priority resolver: bit 0 highest. Picks the lowest-numbered request
// that is not masked and reports it as a level and as a one-hot word.
`timescale 1ns/1ps
module pic_priority (
  input  logic [7:0] req_i,
  input  logic [7:0] mask_i,
  output logic       valid_o,
  output logic [2:0] level_o,
  output logic [7:0] onehot_o
);

  logic [7:0] avail;

  // Scan downwards so the last hit is the highest-priority (lowest) bit
  always_comb begin
    avail    = req_i & ~mask_i;
    valid_o  = |avail;
    level_o  = '0;
    onehot_o = '0;
    for (int i = 7; i >= 0; i--) begin
      if (avail[i]) begin
        level_o     = 3'(i);
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pic.sv
// Eight-input programmable interrupt controller. Latches rising request edges,
// masks and prioritises them, raises int_out and answers a two-pulse intackN
// sequence by placing {OCR[7:3], level} on the shared data bus.
`timescale 1ns/1ps
module pic
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  inout  wire  [7:0] data,
  input  logic [1:0] select,
  input  logic       readwrite,
  input  logic [7:0] intreq,
  input  logic       intackN,
  output logic       int_out
);

  pic_state_e state_q, state_d;
  logic [7:0] ocr_q, ocr_d;
  logic [7:0] imr_q, imr_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] intreq_q;
  logic       ack_q;
  logic       int_out_q, int_out_d;

  logic [7:0] req_edge;
  logic       ack_edge;
  logic       cand_valid;
  logic [2:0] cand_level;
  logic [7:0] cand_onehot;
  logic [7:0] rd_data;
  logic [7:0] vector;
  logic [7:0] data_out;
  logic       data_oe;

  assign req_edge = intreq & ~intreq_q;
  assign ack_edge = ~intackN & ack_q;

  pic_priority u_priority (
    .req_i    (irr_q),
    .mask_i   (imr_q),
    .valid_o  (cand_valid),
    .level_o  (cand_level),
    .onehot_o (cand_onehot)
  );

  // cand_level is informational only; the one-hot form drives the IRR/ISR move
  logic unused_level;
  assign unused_level = ^cand_level;

  // State, registers and input samplers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= StIdle;
      ocr_q     <= '0;
      imr_q     <= '0;
      irr_q     <= '0;
      isr_q     <= '0;
      intreq_q  <= '0;
      ack_q     <= 1'b1;
      int_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ocr_q     <= ocr_d;
      imr_q     <= imr_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      intreq_q  <= intreq;
      ack_q     <= intackN;
      int_out_q <= int_out_d;
    end
  end

  // Acknowledge sequencing, IRR/ISR updates and register writes
  always_comb begin
    state_d = state_q;
    irr_d   = irr_q;
    isr_d   = isr_q;
    ocr_d   = ocr_q;
    imr_d   = imr_q;

    unique case (state_q)
      StIdle: begin
        if (cand_valid) state_d = StPend;
      end
      StPend: begin
        if (ack_edge) begin
          if (cand_valid) begin
            irr_d = irr_q & ~cand_onehot;
            isr_d = cand_onehot;
          end else begin
            isr_d = SPURIOUS_ISR;
          end
          state_d = StInserv;
        end
      end
      StInserv: begin
        if (ack_edge) state_d = StVect;
      end
      StVect: begin
        // Automatic end-of-interrupt once the CPU releases the second ack
        if (intackN) begin
          isr_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new edge on the same cycle as a clear must win
    irr_d = irr_d | req_edge;

    // No strobe: every cycle with readwrite low is a write, except in VECT
    if ((readwrite == RW_WRITE) && (state_q != StVect)) begin
      case (select)
        SEL_OCR: ocr_d = data;
        SEL_IMR: imr_d = data;
        default: ;
      endcase
    end

    int_out_d = (state_d == StPend) || (state_d == StInserv);
  end

  assign int_out = int_out_q;

  // Register read mux
  always_comb begin
    case (select)
      SEL_OCR: rd_data = ocr_q;
      SEL_IMR: rd_data = imr_q;
      SEL_IRR: rd_data = irr_q;
      default: rd_data = isr_q;
    endcase
  end

  assign vector = {ocr_q[7:3], encode_level(isr_q)};

  // Bus driver: the vector has precedence over register reads
  always_comb begin
    data_oe  = 1'b0;
    data_out = rd_data;
    if (resetN) begin
      if (state_q == StVect) begin
        data_oe  = 1'b1;
        data_out = vector;
      end else if ((readwrite == RW_READ) && intackN) begin
        data_oe = 1'b1;
      end
    end
  end

  assign data = data_oe ? data_out : 8'hzz;

endmodule

// File: tb/tb_pic.sv
// Bench for pic: directed scenarios followed by randomized traffic, all checked
// against a transaction-level model of the controller held in the bench.
`timescale 1ns/1ps
module tb_pic;
  import pic_pkg::*;

  logic       clk = 1'b0;
  logic       resetN;
  logic [1:0] select;
  logic       readwrite;
  logic [7:0] intreq;
  logic       intackN;
  logic       int_out;
  wire  [7:0] data;
  logic [7:0] tb_data;
  logic       tb_drv;

  assign data = tb_drv ? tb_data : 8'hzz;

  always #5 clk = ~clk;

  pic dut (
    .clk       (clk),
    .resetN    (resetN),
    .data      (data),
    .select    (select),
    .readwrite (readwrite),
    .intreq    (intreq),
    .intackN   (intackN),
    .int_out   (int_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Model: phase 0 idle, 1 waiting first ack, 2 waiting second ack, 3 vector out
  logic [7:0] m_ocr, m_imr, m_irr, m_isr, m_reqq;
  logic       m_ackq;
  int         m_phase;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] model_reg(input logic [1:0] s);
    case (s)
      2'd0:    return m_ocr;
      2'd1:    return m_imr;
      2'd2:    return m_irr;
      default: return m_isr;
    endcase
  endfunction

  task automatic model_reset();
    m_ocr = 0; m_imr = 0; m_irr = 0; m_isr = 0; m_reqq = 0;
    m_ackq = 1'b1; m_phase = 0;
  endtask

  task automatic model_edge();
    logic [7:0] rise;
    logic       ack_now;
    int         c;
    int         ph;
    rise    = intreq & ~m_reqq;
    ack_now = !intackN && m_ackq;
    c       = lowest(m_irr & ~m_imr);
    ph      = m_phase;
    if (!resetN) begin
      model_reset();
      return;
    end
    case (ph)
      0: if (c >= 0) m_phase = 1;
      1: if (ack_now) begin
           if (c >= 0) begin m_irr[c] = 1'b0; m_isr = 8'h00; m_isr[c] = 1'b1; end
           else m_isr = 8'h80;
           m_phase = 2;
         end
      2: if (ack_now) m_phase = 3;
      default: if (intackN) begin m_isr = 0; m_phase = 0; end
    endcase
    m_irr = m_irr | rise;
    if (!readwrite && ph != 3) begin
      if (select == 2'd0) m_ocr = tb_data;
      else if (select == 2'd1) m_imr = tb_data;
    end
    m_reqq = intreq;
    m_ackq = intackN;
  endtask

  // One clock: advance the model on the edge, then compare just after it
  task automatic step();
    logic [7:0] vec;
    @(posedge clk);
    model_edge();
    #1;
    check_eq("int_out", {7'd0, int_out}, {7'd0, (m_phase == 1 || m_phase == 2)});
    if (resetN) begin
      vec = {m_ocr[7:3], 3'(lowest(m_isr))};
      if (m_phase == 3) check_eq("vector", data, vec);
      else if (tb_drv) check_eq("bus_release", data, tb_data);
      else if (readwrite && intackN) check_eq("read", data, model_reg(select));
    end
  endtask

  task automatic drive_write(input logic [1:0] sel, input logic [7:0] val);
    select = sel; readwrite = 1'b0; tb_data = val; tb_drv = 1'b1;
    step();
    readwrite = 1'b1; tb_drv = 1'b0;
  endtask

  task automatic wait_int(output int n);
    n = 0;
    while (!int_out && n < 10) begin step(); n++; end
  endtask

  task automatic read_all_zero(input string tag);
    for (int s = 0; s < 4; s++) begin
      select = 2'(s); #1;
      check_eq(tag, data, 8'h00);
    end
  endtask

  int  n;
  bit  safe;
  int  r;

  initial begin
    resetN = 1'b0; select = SEL_OCR; readwrite = RW_READ; intreq = 0;
    intackN = 1'b1; tb_drv = 1'b0; tb_data = 0;
    model_reset();
    step(); step();
    resetN = 1'b1;
    read_all_zero("reset_read");
    check_eq("reset_int_out", {7'd0, int_out}, 8'd0);

    // Register write/read
    drive_write(SEL_OCR, 8'hAA);
    drive_write(SEL_IMR, 8'h22);
    select = SEL_OCR; #1 check_eq("ocr_rd", data, 8'hAA);
    select = SEL_IMR; #1 check_eq("imr_rd", data, 8'h22);
    select = SEL_IRR; #1 check_eq("irr_rd", data, 8'h00);
    select = SEL_ISR; #1 check_eq("isr_rd", data, 8'h00);

    // Single request on level 2
    intreq = 8'h04;
    wait_int(n);
    check_eq("irq_latency", 8'(n), 8'd2);
    intreq = 8'h00; intackN = 1'b0; step();
    intackN = 1'b1; select = SEL_ISR; step();
    check_eq("isr_after_ack", data, 8'h04);
    repeat (7) step();
    intackN = 1'b0; step();
    check_eq("vector_lvl2", data, 8'hAA);
    check_eq("int_fall", {7'd0, int_out}, 8'd0);
    intackN = 1'b1; step();
    check_eq("isr_eoi", data, 8'h00);

    // Two requests: level 0 first, then level 2
    intreq = 8'h05;
    wait_int(n);
    intreq = 8'h00;
    intackN = 1'b0; step(); intackN = 1'b1; step();
    intackN = 1'b0; step();
    check_eq("vector_lvl0", data, 8'hA8);
    intackN = 1'b1; step();
    check_eq("int_drop", {7'd0, int_out}, 8'd0);
    wait_int(n);
    check_eq("int_rerise", {7'd0, int_out}, 8'd1);
    select = SEL_IRR; #1 check_eq("irr_second", data, 8'h04);
    intackN = 1'b0; step(); intackN = 1'b1; step();
    intackN = 1'b0; step();
    check_eq("vector_second", data, 8'hAA);
    intackN = 1'b1; step(); step();
    check_eq("int_stays_low", {7'd0, int_out}, 8'd0);

    // Masked request, then unmask
    drive_write(SEL_IMR, 8'h04);
    intreq = 8'h04;
    repeat (4) step();
    check_eq("masked_int", {7'd0, int_out}, 8'd0);
    select = SEL_IRR; #1 check_eq("masked_irr", data, 8'h04);
    drive_write(SEL_IMR, 8'h00);
    step();
    check_eq("unmask_rise", {7'd0, int_out}, 8'd1);
    intreq = 8'h00;

    // Reset during INSERV
    intackN = 1'b0; step(); intackN = 1'b1; step();
    resetN = 1'b0; #1;
    check_eq("rst_int_out", {7'd0, int_out}, 8'd0);
    tb_drv = 1'b1; tb_data = 8'h5A; #1;
    check_eq("rst_bus_release", data, 8'h5A);
    tb_drv = 1'b0;
    model_reset();
    step(); step();
    resetN = 1'b1;
    read_all_zero("rst_regs");

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) intreq = 8'($urandom);
      if ($urandom_range(0, 3) == 0) intackN = ~intackN;
      select = 2'($urandom);
      readwrite = RW_READ; tb_drv = 1'b0;
      safe = (m_phase != 3) && !(m_phase == 2 && !intackN && m_ackq);
      r = $urandom_range(0, 9);
      if (safe && r == 0) begin
        readwrite = RW_WRITE; tb_drv = 1'b1;
        tb_data = (select == SEL_IMR) ? (8'($urandom) & 8'($urandom)) : 8'($urandom);
      end else if (safe && r == 1 && !intackN) begin
        tb_drv = 1'b1; tb_data = 8'($urandom);
      end
      if ($urandom_range(0, 499) == 0) begin
        resetN = 1'b0; tb_drv = 1'b0; readwrite = RW_READ;
        model_reset();
        step();
        resetN = 1'b1;
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
